sample_capture: RTL and testbench

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/filter_pkg.sv | 9 +
 rtl/sample_capture_if.sv | 35 +++
 rtl/sample_fifo_mem.sv | 39 +++
 rtl/sample_capture.sv | 110 +++++++++++
 tb/tb_sample_capture.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Types and widths shared between the decimation filter and the sample capture
// FIFO, so that both sides agree on the sample format.
package filter_pkg;

  localparam int FILTER_DW = 11;

  typedef logic signed [FILTER_DW-1:0] sample_t;

endpackage

// File: rtl/sample_capture_if.sv
// Bus between a sample producer/consumer (master) and the capture FIFO (slave):
// write strobe, read request, clear, and the registered status/read outputs.
interface sample_capture_if
  import filter_pkg::*;
#(
  parameter int DW    = FILTER_DW,
  parameter int DEPTH = 8,
  parameter int CW    = 16
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          vin;
  logic [DW-1:0] din;
  logic          rd;
  logic          clr;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          ovf;
  logic [CW-1:0] cnt;

  modport master (
    output vin, din, rd, clr,
    input  rdata, rvalid, empty, full, level, ovf, cnt
  );

  modport slave (
    input  vin, din, rd, clr,
    output rdata, rvalid, empty, full, level, ovf, cnt
  );

endinterface

// File: rtl/sample_fifo_mem.sv
// DEPTH x DW sample storage: one write port and one registered read port.
// The array itself is never reset; only the read register is.
module sample_fifo_mem #(
  parameter  int DW    = 11,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A read of the slot being written in the same cycle returns the old contents,
  // which is what a simultaneous read/write on a full FIFO needs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_capture.sv
// Capture FIFO for filter output samples: pointers, occupancy flags, sticky
// overflow and a saturating accepted-sample counter around sample_fifo_mem.
module sample_capture
  import filter_pkg::*;
#(
  parameter int DW    = FILTER_DW,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  sample_capture_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [LW-1:0] r_level;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;
  logic          r_rvalid;

  logic          w_wrAcc;
  logic          w_rdAcc;
  logic          w_drop;
  logic [LW-1:0] w_levelNext;
  logic [DW-1:0] w_rdata;

  // A full FIFO still accepts a write when a read frees the head slot this cycle.
  assign w_rdAcc = bus.rd && !r_empty;
  assign w_wrAcc = bus.vin && (!r_full || bus.rd);
  assign w_drop  = bus.vin && r_full && !bus.rd;

  always_comb begin
    w_levelNext = r_level;
    case ({w_wrAcc, w_rdAcc})
      2'b10:   w_levelNext = r_level + LW'(1);
      2'b01:   w_levelNext = r_level - LW'(1);
      default: w_levelNext = r_level;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_level  <= w_levelNext;
      r_empty  <= (w_levelNext == '0);
      r_full   <= (w_levelNext == FULL_LEVEL);
      r_rvalid <= w_rdAcc;
    end
  end

  // Clear wins over a same-cycle drop or accepted write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (bus.clr) begin
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_wrAcc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  sample_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_wrAcc),
    .i_waddr (r_wrPtr),
    .i_wdata (bus.din),
    .i_re    (w_rdAcc),
    .i_raddr (r_rdPtr),
    .o_rdata (w_rdata)
  );

  assign bus.rdata  = w_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.empty  = r_empty;
  assign bus.full   = r_full;
  assign bus.level  = r_level;
  assign bus.ovf    = r_ovf;
  assign bus.cnt    = r_cnt;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: ordered readback, overflow and drop,
// full read/write collision, empty reads, pointer wrap, clear and async reset.
module tb_sample_capture;
  import filter_pkg::*;

  localparam int DW    = FILTER_DW;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  sample_capture_if #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) bus ();

  sample_capture #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic applyStimulus(input logic vin, input logic [DW-1:0] din,
                               input logic rd, input logic clr);
    bus.vin = vin;
    bus.din = din;
    bus.rd  = rd;
    bus.clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sample_t negSample;
    negSample = -7;

    rst_n   = 1'b0;
    bus.vin = 1'b0;
    bus.din = '0;
    bus.rd  = 1'b0;
    bus.clr = 1'b0;
    #12;
    checkOutput("reset_empty",  32'(bus.empty),  32'd1);
    checkOutput("reset_full",   32'(bus.full),   32'd0);
    checkOutput("reset_level",  32'(bus.level),  32'd0);
    checkOutput("reset_ovf",    32'(bus.ovf),    32'd0);
    checkOutput("reset_cnt",    32'(bus.cnt),    32'd0);
    checkOutput("reset_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("reset_rdata",  32'(bus.rdata),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] three samples in, three out");
    applyStimulus(1'b1, 11'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, negSample, 1'b0, 1'b0);
    applyStimulus(1'b1, 11'd1023, 1'b0, 1'b0);
    checkOutput("w3_level", 32'(bus.level), 32'd3);
    checkOutput("w3_cnt",   32'(bus.cnt),   32'd3);
    checkOutput("w3_empty", 32'(bus.empty), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("r1_rvalid", 32'(bus.rvalid), 32'd1);
    checkOutput("r1_rdata",  32'(bus.rdata),  32'h005);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("r2_rvalid", 32'(bus.rvalid), 32'd1);
    checkOutput("r2_rdata",  32'(bus.rdata),  32'h7F9);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("r3_rvalid", 32'(bus.rvalid), 32'd1);
    checkOutput("r3_rdata",  32'(bus.rdata),  32'h3FF);
    checkOutput("r3_empty",  32'(bus.empty),  32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("idle_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("idle_level",  32'(bus.level),  32'd0);
    checkOutput("idle_cnt",    32'(bus.cnt),    32'd3);

    $display("[TB] fill past full");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr_cnt", 32'(bus.cnt), 32'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, DW'(32'h010 + i), 1'b0, 1'b0);
      if (i == 7) begin
        checkOutput("fill8_full",  32'(bus.full),  32'd1);
        checkOutput("fill8_level", 32'(bus.level), 32'd8);
        checkOutput("fill8_ovf",   32'(bus.ovf),   32'd0);
      end
    end
    checkOutput("drop_ovf",   32'(bus.ovf),   32'd1);
    checkOutput("drop_cnt",   32'(bus.cnt),   32'd8);
    checkOutput("drop_level", 32'(bus.level), 32'd8);
    checkOutput("drop_full",  32'(bus.full),  32'd1);

    $display("[TB] read and write together while full");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr2_ovf",   32'(bus.ovf),   32'd0);
    checkOutput("clr2_cnt",   32'(bus.cnt),   32'd0);
    checkOutput("clr2_level", 32'(bus.level), 32'd8);
    applyStimulus(1'b1, 11'h055, 1'b1, 1'b0);
    checkOutput("rw_rvalid", 32'(bus.rvalid), 32'd1);
    checkOutput("rw_rdata",  32'(bus.rdata),  32'h010);
    checkOutput("rw_level",  32'(bus.level),  32'd8);
    checkOutput("rw_full",   32'(bus.full),   32'd1);
    checkOutput("rw_ovf",    32'(bus.ovf),    32'd0);
    checkOutput("rw_cnt",    32'(bus.cnt),    32'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain_rvalid", 32'(bus.rvalid), 32'd1);
      checkOutput("drain_rdata", 32'(bus.rdata), (i < 8) ? 32'h010 + 32'(i) : 32'h055);
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    $display("[TB] reads on an empty FIFO");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("erd_rvalid", 32'(bus.rvalid), 32'd0);
      checkOutput("erd_level",  32'(bus.level),  32'd0);
      checkOutput("erd_rdata",  32'(bus.rdata),  32'h055);
    end
    applyStimulus(1'b1, 11'h123, 1'b1, 1'b0);
    checkOutput("nobypass_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("nobypass_level",  32'(bus.level),  32'd1);
    checkOutput("nobypass_rdata",  32'(bus.rdata),  32'h055);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("late_rvalid", 32'(bus.rvalid), 32'd1);
    checkOutput("late_rdata",  32'(bus.rdata),  32'h123);
    checkOutput("late_cnt",    32'(bus.cnt),    32'd2);

    $display("[TB] interleaved pairs across pointer wrap");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("wrap_rvalid", 32'(bus.rvalid), 32'd1);
      checkOutput("wrap_rdata",  32'(bus.rdata),  32'h100 + 32'(i));
    end
    checkOutput("wrap_cnt",   32'(bus.cnt),   32'd22);
    checkOutput("wrap_level", 32'(bus.level), 32'd0);
    applyStimulus(1'b1, 11'h200, 1'b0, 1'b1);
    checkOutput("clrw_cnt",   32'(bus.cnt),   32'd0);
    checkOutput("clrw_ovf",   32'(bus.ovf),   32'd0);
    checkOutput("clrw_level", 32'(bus.level), 32'd1);

    $display("[TB] clear against a same-cycle drop");
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
    end
    checkOutput("refill_full", 32'(bus.full), 32'd1);
    checkOutput("refill_cnt",  32'(bus.cnt),  32'd7);
    applyStimulus(1'b1, 11'h2FF, 1'b0, 1'b1);
    checkOutput("clrdrop_ovf",   32'(bus.ovf),   32'd0);
    checkOutput("clrdrop_cnt",   32'(bus.cnt),   32'd0);
    checkOutput("clrdrop_level", 32'(bus.level), 32'd8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("head_rdata", 32'(bus.rdata), 32'h200 + 32'(i));
    end
    checkOutput("mid_level", 32'(bus.level), 32'd5);

    $display("[TB] asynchronous reset mid-stream");
    bus.rd = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_level",  32'(bus.level),  32'd0);
    checkOutput("areset_empty",  32'(bus.empty),  32'd1);
    checkOutput("areset_full",   32'(bus.full),   32'd0);
    checkOutput("areset_ovf",    32'(bus.ovf),    32'd0);
    checkOutput("areset_cnt",    32'(bus.cnt),    32'd0);
    checkOutput("areset_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("areset_rdata",  32'(bus.rdata),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("post_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("post_empty",  32'(bus.empty),  32'd1);
    applyStimulus(1'b1, 11'h3AB, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("post_rdata", 32'(bus.rdata), 32'h3AB);
    checkOutput("post_cnt",   32'(bus.cnt),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
